ifu_fetch: RTL and testbench

//  Instruction-fetch initiator for the pipelined MIPS core: owns the PC, drives the

---
 rtl/ifu_fetch.sv | 177 +++++++++++++++++
 tb/tb_ifu_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
//-----------------------------------------------------------------------------
// ifu_fetch
//
// Instruction-fetch stage of the pipelined MIPS core. Owns the fetch PC,
// drives the word-aligned byte address of a combinational, same-cycle
// instruction-memory read port, and captures the returned word together with
// its PC into the IF/ID pipeline register.
//
// Redirects (branch / jump / jump-register) are resolved in D and applied on
// the next edge. There is one architectural delay slot: the word fetched in
// the redirect cycle still enters IF/ID, and nothing is ever flushed.
//
// A fetch from a PC that is misaligned or outside the instruction memory
// window is not trapped here. The word is replaced by NOP_WORD and tagged with
// fetch_err_d, so a later stage can decide what to do with it.
//
// Parameters
//   PC_RESET  PC after reset; base byte address of instruction memory
//   IM_WORDS  instruction memory depth in 32-bit words
//   NOP_WORD  word injected into IF/ID for an illegal fetch
//
// Ports
//   clk          in   1   clock; all state updates on the rising edge
//   reset        in   1   synchronous active-high reset, overrides stall
//   stall        in   1   hold PC, IF/ID and fetch counter
//   br_taken     in   1   conditional branch in D is taken
//   br_target    in   32  branch target
//   j_en         in   1   j/jal in D
//   j_target     in   32  jump target
//   jr_en        in   1   jr/jalr in D
//   jr_target    in   32  register jump target (already forwarded)
//   im_addr      out  32  byte address to instruction memory (= fetch PC)
//   im_data      in   32  instruction word returned in the same cycle
//   instr_d      out  32  IF/ID instruction
//   pc_d         out  32  IF/ID PC
//   pc8_d        out  32  IF/ID PC+8 (link value for jal/jalr)
//   valid_d      out  1   IF/ID holds a real fetch
//   fetch_err_d  out  1   IF/ID word came from an illegal PC
//   fetch_cnt    out  32  number of IF/ID advances since reset (wraps)
//-----------------------------------------------------------------------------
module ifu_fetch #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int unsigned IM_WORDS = 1024,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        j_en,
   input  logic [31:0] j_target,
   input  logic        jr_en,
   input  logic [31:0] jr_target,
   output logic [31:0] im_addr,
   input  logic [31:0] im_data,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        valid_d,
   output logic        fetch_err_d,
   output logic [31:0] fetch_cnt
);

   // Size of the instruction memory window in bytes.
   localparam logic [31:0] IM_BYTES = 32'(4 * IM_WORDS);

   //--------------------------------------------------------------------------
   // State
   //--------------------------------------------------------------------------
   logic [31:0] pc_f_q,    pc_f_d;      // fetch PC
   logic [31:0] id_instr_q, id_instr_d; // IF/ID instruction
   logic [31:0] id_pc_q,   id_pc_d;     // IF/ID PC
   logic [31:0] id_pc8_q,  id_pc8_d;    // IF/ID PC+8
   logic        id_valid_q, id_valid_d; // IF/ID holds a real fetch
   logic        id_err_q,  id_err_d;    // IF/ID word was NOP-substituted
   logic [31:0] cnt_q,     cnt_d;       // IF/ID advance counter

   //--------------------------------------------------------------------------
   // Fetch legality
   //--------------------------------------------------------------------------
   // The offset is an unsigned 32-bit subtract on purpose: a PC below the base
   // wraps to a huge offset, so a single compare rejects both "below base" and
   // "above top" without a second comparator.
   logic [31:0] pc_off;
   logic        legal_f;

   assign pc_off  = pc_f_q - PC_RESET;
   assign legal_f = (pc_f_q[1:0] == 2'b00) && (pc_off < IM_BYTES);

   // The memory port is driven straight from the PC register, so no stall or
   // redirect input has a combinational path to im_addr.
   assign im_addr = pc_f_q;

   //--------------------------------------------------------------------------
   // Next PC
   //--------------------------------------------------------------------------
   // jr beats j beats branch. Several enables at once are not an error; the
   // highest-priority one simply wins. Targets are loaded unchanged, even when
   // misaligned or out of range; the legality check above catches that fetch.
   logic [31:0] npc;

   always_comb begin
      if (jr_en) begin
         npc = jr_target;
      end else if (j_en) begin
         npc = j_target;
      end else if (br_taken) begin
         npc = br_target;
      end else begin
         npc = pc_f_q + 32'd4;
      end
   end

   //--------------------------------------------------------------------------
   // Next-state logic
   //--------------------------------------------------------------------------
   always_comb begin
      // NOTE: every next-state signal gets a hold value first, so no path
      // through this block leaves a variable unassigned and no latch is inferred.
      pc_f_d     = pc_f_q;
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_pc8_d   = id_pc8_q;
      id_valid_d = id_valid_q;
      id_err_d   = id_err_q;
      cnt_d      = cnt_q;

      // While stalled the D instruction is held too, so its redirect request
      // is re-presented when the stall drops; ignoring it here loses nothing.
      if (!stall) begin
         pc_f_d     = npc;
         id_instr_d = legal_f ? im_data : NOP_WORD;
         id_err_d   = ~legal_f;
         id_pc_d    = pc_f_q;
         id_pc8_d   = pc_f_q + 32'd8;
         id_valid_d = 1'b1;
         cnt_d      = cnt_q + 32'd1;
      end
   end

   //--------------------------------------------------------------------------
   // Registers
   //--------------------------------------------------------------------------
   // NOTE: non-blocking assignments here so every register samples the values
   // from before this edge, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f_q     <= PC_RESET;
         id_instr_q <= NOP_WORD;
         id_pc_q    <= PC_RESET;
         id_pc8_q   <= PC_RESET + 32'd8;
         id_valid_q <= 1'b0;
         id_err_q   <= 1'b0;
         cnt_q      <= 32'd0;
      end else begin
         pc_f_q     <= pc_f_d;
         id_instr_q <= id_instr_d;
         id_pc_q    <= id_pc_d;
         id_pc8_q   <= id_pc8_d;
         id_valid_q <= id_valid_d;
         id_err_q   <= id_err_d;
         cnt_q      <= cnt_d;
      end
   end

   //--------------------------------------------------------------------------
   // Outputs
   //--------------------------------------------------------------------------
   assign instr_d     = id_instr_q;
   assign pc_d        = id_pc_q;
   assign pc8_d       = id_pc8_q;
   assign valid_d     = id_valid_q;
   assign fetch_err_d = id_err_q;
   assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
//-----------------------------------------------------------------------------
// tb_ifu_fetch
//
// Self-checking bench for ifu_fetch: a directed vector table covering the
// fetch, redirect, stall and illegal-PC cases, a reset-during-stall sequence,
// then a long randomized run compared against a transaction-level model.
//-----------------------------------------------------------------------------
module tb_ifu_fetch;

   localparam logic [31:0] BASE  = 32'h0000_3000;
   localparam int          WORDS = 1024;
   localparam logic [31:0] NOP   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, stall;
   logic        br_taken, j_en, jr_en;
   logic [31:0] br_target, j_target, jr_target;
   logic [31:0] im_addr, im_data;
   logic [31:0] instr_d, pc_d, pc8_d, fetch_cnt;
   logic        valid_d, fetch_err_d;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   ifu_fetch #(.PC_RESET(BASE), .IM_WORDS(WORDS), .NOP_WORD(NOP)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .br_taken(br_taken), .br_target(br_target),
      .j_en(j_en), .j_target(j_target),
      .jr_en(jr_en), .jr_target(jr_target),
      .im_addr(im_addr), .im_data(im_data),
      .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d),
      .valid_d(valid_d), .fetch_err_d(fetch_err_d), .fetch_cnt(fetch_cnt)
   );

   // Instruction memory: returns its word for any address inside the window
   // (misaligned ones included) and a nonzero garbage word outside, so that
   // NOP substitution is always visible.
   logic [31:0] mem [WORDS];
   logic [31:0] mem_off;

   always_comb begin
      mem_off = im_addr - BASE;
      if (mem_off < 32'(4 * WORDS)) im_data = mem[mem_off[11:2]];
      else                          im_data = 32'hBAD0_BAD0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input logic st, input logic br, input logic [31:0] brt,
                        input logic j, input logic [31:0] jt,
                        input logic jr, input logic [31:0] jrt);
      stall = st; br_taken = br; br_target = brt;
      j_en = j; j_target = jt; jr_en = jr; jr_target = jrt;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " im_addr"}, im_addr, BASE);
      check({tag, " instr_d"}, instr_d, NOP);
      check({tag, " pc_d"}, pc_d, BASE);
      check({tag, " pc8_d"}, pc8_d, BASE + 32'd8);
      check({tag, " valid_d"}, 32'(valid_d), 32'd0);
      check({tag, " fetch_err_d"}, 32'(fetch_err_d), 32'd0);
      check({tag, " fetch_cnt"}, fetch_cnt, 32'd0);
   endtask

   //--------------------------------------------------------------------------
   // Reference model (transaction level)
   //--------------------------------------------------------------------------
   logic [31:0] m_pc, m_instr, m_pcd, m_cnt;
   logic        m_valid, m_err;

   function automatic bit is_legal(input logic [31:0] pc);
      return (pc % 4 == 0) && (pc >= BASE) && (pc <= BASE + 32'(4 * (WORDS - 1)));
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      return mem[(pc - BASE) / 4];
   endfunction

   task automatic model_reset();
      m_pc = BASE; m_instr = NOP; m_pcd = BASE; m_cnt = 0; m_valid = 0; m_err = 0;
   endtask

   // One clock edge with the currently driven inputs.
   task automatic model_edge();
      if (reset) begin
         model_reset();
      end else if (!stall) begin
         m_err   = !is_legal(m_pc);
         m_instr = m_err ? NOP : word_at(m_pc);
         m_pcd   = m_pc;
         m_valid = 1;
         m_cnt   = m_cnt + 1;
         if (jr_en)         m_pc = jr_target;
         else if (j_en)     m_pc = j_target;
         else if (br_taken) m_pc = br_target;
         else               m_pc = m_pc + 4;
      end
   endtask

   function automatic logic [31:0] rand_target();
      case ($urandom_range(0, 7))
         0:       return $urandom();                              // anywhere
         1:       return BASE + 32'($urandom_range(0, 4095));     // maybe misaligned
         2:       return BASE - 32'd4;                            // just below
         3:       return BASE + 32'(4 * WORDS);                   // just above
         4:       return BASE + 32'(4 * (WORDS - 1));             // last word
         default: return BASE + 32'(4 * $urandom_range(0, WORDS - 1));
      endcase
   endfunction

   //--------------------------------------------------------------------------
   // Directed vector table
   //--------------------------------------------------------------------------
   typedef struct {
      logic        st;
      logic        br;  logic [31:0] brt;
      logic        j;   logic [31:0] jt;
      logic        jr;  logic [31:0] jrt;
      logic [31:0] e_addr;  // im_addr after the edge
      logic [31:0] e_pcd;   // pc_d after the edge
      int          e_idx;   // memory word index in instr_d, -1 = NOP with error
      logic [31:0] e_cnt;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = $urandom() | 32'h0000_0001;
      drive(0, 0, 0, 0, 0, 0, 0);

      //         st br brt           j  jt            jr jrt           addr          pcd           idx   cnt
      vecs[0]  = '{0, 0, 0,          0, 0,            0, 0,            32'h3004,     32'h3000,     0,    1};
      vecs[1]  = '{0, 0, 0,          0, 0,            0, 0,            32'h3008,     32'h3004,     1,    2};
      vecs[2]  = '{0, 0, 0,          0, 0,            0, 0,            32'h300C,     32'h3008,     2,    3};
      vecs[3]  = '{0, 0, 0,          0, 0,            0, 0,            32'h3010,     32'h300C,     3,    4};
      vecs[4]  = '{0, 1, 32'h3040,   0, 0,            0, 0,            32'h3040,     32'h3010,     4,    5};
      vecs[5]  = '{0, 0, 0,          0, 0,            0, 0,            32'h3044,     32'h3040,     16,   6};
      vecs[6]  = '{0, 1, 32'h3300,   1, 32'h3200,     1, 32'h3100,     32'h3100,     32'h3044,     17,   7};
      vecs[7]  = '{1, 0, 0,          1, 32'h3200,     0, 0,            32'h3100,     32'h3044,     17,   7};
      vecs[8]  = '{1, 0, 0,          1, 32'h3200,     0, 0,            32'h3100,     32'h3044,     17,   7};
      vecs[9]  = '{1, 0, 0,          1, 32'h3200,     0, 0,            32'h3100,     32'h3044,     17,   7};
      vecs[10] = '{0, 0, 0,          0, 0,            0, 0,            32'h3104,     32'h3100,     64,   8};
      vecs[11] = '{0, 0, 0,          0, 0,            1, 32'h3002,     32'h3002,     32'h3104,     65,   9};
      vecs[12] = '{0, 0, 0,          0, 0,            1, 32'h4000,     32'h4000,     32'h3002,     -1,   10};
      vecs[13] = '{0, 0, 0,          0, 0,            1, 32'h2FFC,     32'h2FFC,     32'h4000,     -1,   11};
      vecs[14] = '{0, 0, 0,          0, 0,            1, 32'h3FFC,     32'h3FFC,     32'h2FFC,     -1,   12};
      vecs[15] = '{0, 0, 0,          1, 32'hFFFF_FFFC, 0, 0,           32'hFFFF_FFFC, 32'h3FFC,    1023, 13};
      vecs[16] = '{0, 0, 0,          0, 0,            0, 0,            32'h0000_0000, 32'hFFFF_FFFC, -1, 14};
      vecs[17] = '{0, 1, 32'h3000,   0, 0,            0, 0,            32'h3000,     32'h0000_0000, -1,  15};
      vecs[18] = '{0, 0, 0,          0, 0,            0, 0,            32'h3004,     32'h3000,     0,    16};

      // Reset held for two edges.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");

      // Release: PC sits at the base, nothing valid yet.
      reset = 1'b0;
      #1;
      check("release im_addr", im_addr, BASE);
      check("release valid_d", 32'(valid_d), 32'd0);

      for (int v = 0; v < NV; v++) begin
         drive(vecs[v].st, vecs[v].br, vecs[v].brt, vecs[v].j, vecs[v].jt,
               vecs[v].jr, vecs[v].jrt);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d im_addr", v), im_addr, vecs[v].e_addr);
         check($sformatf("vec%0d pc_d", v), pc_d, vecs[v].e_pcd);
         check($sformatf("vec%0d pc8_d", v), pc8_d, vecs[v].e_pcd + 32'd8);
         check($sformatf("vec%0d instr_d", v), instr_d,
               (vecs[v].e_idx < 0) ? NOP : mem[vecs[v].e_idx]);
         check($sformatf("vec%0d fetch_err_d", v), 32'(fetch_err_d),
               (vecs[v].e_idx < 0) ? 32'd1 : 32'd0);
         check($sformatf("vec%0d valid_d", v), 32'(valid_d), 32'd1);
         check($sformatf("vec%0d fetch_cnt", v), fetch_cnt, vecs[v].e_cnt);
      end

      // Reset together with stall and a pending jump mid-run: reset wins.
      reset = 1'b1;
      drive(1, 1, 32'h3300, 1, 32'h3200, 1, 32'h3100);
      @(posedge clk);
      #1;
      check_reset_state("reset+stall");

      // Randomized run against the model.
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         drive($urandom_range(0, 3) == 0,
               $urandom_range(0, 5) == 0, rand_target(),
               $urandom_range(0, 7) == 0, rand_target(),
               $urandom_range(0, 9) == 0, rand_target());
         #1;
         // Inputs just changed; the fetch address must not react before the edge.
         check("rand im_addr pre-edge", im_addr, m_pc);
         @(posedge clk);
         model_edge();
         #1;
         check("rand im_addr", im_addr, m_pc);
         check("rand instr_d", instr_d, m_instr);
         check("rand pc_d", pc_d, m_pcd);
         check("rand pc8_d", pc8_d, m_pcd + 32'd8);
         check("rand valid_d", 32'(valid_d), 32'(m_valid));
         check("rand fetch_err_d", 32'(fetch_err_d), 32'(m_err));
         check("rand fetch_cnt", fetch_cnt, m_cnt);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
